// File: rtl/l3_pkg.sv
// l3_pkg - shared types and helpers for the L3 bank front-end.
//
// Contents:
//   L3_WORD_W / L3_RAM_AW / L3_BANK_W - RAM32 word width, word address width, bank index width
//   l3_bank() / l3_word()             - split a request address into bank index and word
//   l3_rsp_t                          - response entry {rdata, id, err} held in the response FIFO
package l3_pkg;

    localparam int L3_WORD_W   = 32;
    localparam int L3_RAM_AW   = 5;
    localparam int L3_BANK_W   = 4;
    localparam int L3_ADDR_W   = L3_BANK_W + L3_RAM_AW;
    // Widest tag a response entry can carry; narrower tags are zero-extended.
    localparam int L3_ID_MAX_W = 16;

    typedef struct packed {
        logic [L3_WORD_W-1:0]   rdata;
        logic [L3_ID_MAX_W-1:0] id;
        logic                   err;
    } l3_rsp_t;

    function automatic logic [L3_BANK_W-1:0] l3_bank(input logic [L3_ADDR_W-1:0] addr);
        return L3_BANK_W'(addr >> L3_RAM_AW);
    endfunction

    function automatic logic [L3_RAM_AW-1:0] l3_word(input logic [L3_ADDR_W-1:0] addr);
        return L3_RAM_AW'(addr);
    endfunction

endpackage

// File: rtl/l3_rsp_fifo.sv
// l3_rsp_fifo - synchronous FIFO with occupancy count, any depth >= 2.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   push, push_data     - write one entry (never issued when full)
//   pop, pop_data       - head entry (zero while empty); pop never issued when empty
//   count               - number of entries held
module l3_rsp_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    import l3_pkg::*;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Explicit wrap at DEPTH-1 so non-power-of-2 depths never index past the array.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the empty-gating below hides stale entries.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/l3_bank_ctrl.sv
// l3_bank_ctrl - request front-end for the NUM_BANKS RAM32 macros of the L3 block.
//
// Ports:
//   clk, rst_n                        - clock (also every RAM32 CLK), async active-low reset
//   req_valid/req_ready               - request handshake
//   req_we, req_addr, req_wdata, req_id - request: write flag, {bank[8:5], word[4:0]}, data, tag
//   rsp_valid/rsp_ready               - response handshake
//   rsp_rdata, rsp_id, rsp_err        - read data (0 for writes/errors), echoed tag, bad-bank flag
//   ram_a, ram_d, ram_we, ram_q       - per-bank RAM32 A/D/WE/Q, bank b in slice b
module l3_bank_ctrl
    import l3_pkg::*;
#(
    parameter int NUM_BANKS = 12,
    parameter int RSP_DEPTH = 3,
    parameter int ID_W      = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_we,
    input  logic [8:0]                     req_addr,
    input  logic [L3_WORD_W-1:0]           req_wdata,
    input  logic [ID_W-1:0]                req_id,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [L3_WORD_W-1:0]           rsp_rdata,
    output logic [ID_W-1:0]                rsp_id,
    output logic                           rsp_err,
    output logic [NUM_BANKS*L3_RAM_AW-1:0] ram_a,
    output logic [NUM_BANKS*L3_WORD_W-1:0] ram_d,
    output logic [NUM_BANKS-1:0]           ram_we,
    input  logic [NUM_BANKS*L3_WORD_W-1:0] ram_q
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    logic                 accept;
    logic [L3_BANK_W-1:0] req_bank;
    logic [L3_RAM_AW-1:0] req_word;
    logic                 req_in_range;

    logic                 inflight_valid;
    logic                 inflight_we;
    logic [L3_BANK_W-1:0] inflight_bank;
    logic [ID_W-1:0]      inflight_id;
    logic                 inflight_err;

    logic [CNT_W-1:0]     fifo_count;
    logic [CNT_W:0]       occupancy;
    logic [L3_WORD_W-1:0] bank_q;
    l3_rsp_t              push_rsp;
    l3_rsp_t              head_rsp;
    logic                 unused_id_bits;

    assign req_bank     = l3_bank(req_addr);
    assign req_word     = l3_word(req_addr);
    assign req_in_range = ({1'b0, req_bank} < (L3_BANK_W + 1)'(NUM_BANKS));

    // Credits come only from registered state, so req_ready has no path from req_valid or rsp_ready.
    // Counting the in-flight entry guarantees its T1 push always finds room.
    assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_valid);
    assign req_ready = (occupancy < (CNT_W + 1)'(RSP_DEPTH));
    assign accept    = req_valid && req_ready;

    // Only the addressed bank sees a non-zero A/D/WE, and only in the accept cycle.
    always_comb begin
        ram_a  = '0;
        ram_d  = '0;
        ram_we = '0;
        if (accept && req_in_range) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (req_bank == L3_BANK_W'(b)) begin
                    ram_a[b*L3_RAM_AW +: L3_RAM_AW] = req_word;
                    ram_d[b*L3_WORD_W +: L3_WORD_W] = req_wdata;
                    ram_we[b]                       = req_we;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_valid <= 1'b0;
            inflight_we    <= 1'b0;
            inflight_bank  <= '0;
            inflight_id    <= '0;
            inflight_err   <= 1'b0;
        end else begin
            inflight_valid <= accept;
            if (accept) begin
                inflight_we   <= req_we;
                inflight_bank <= req_bank;
                inflight_id   <= req_id;
                inflight_err  <= !req_in_range;
            end
        end
    end

    // Q of the bank accessed last cycle; out-of-range banks select nothing.
    always_comb begin
        bank_q = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (inflight_bank == L3_BANK_W'(b)) bank_q = ram_q[b*L3_WORD_W +: L3_WORD_W];
        end
    end

    always_comb begin
        push_rsp       = '0;
        push_rsp.rdata = (inflight_we || inflight_err) ? '0 : bank_q;
        push_rsp.id    = L3_ID_MAX_W'(inflight_id);
        push_rsp.err   = inflight_err;
    end

    l3_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH ($bits(l3_rsp_t))
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_valid),
        .push_data (push_rsp),
        .pop       (rsp_valid && rsp_ready),
        .pop_data  (head_rsp),
        .count     (fifo_count)
    );

    assign rsp_valid      = (fifo_count != '0);
    assign rsp_rdata      = head_rsp.rdata;
    assign rsp_id         = head_rsp.id[ID_W-1:0];
    assign rsp_err        = head_rsp.err;
    // Tag bits above ID_W are always zero.
    assign unused_id_bits = ^head_rsp.id;

endmodule

// File: tb/tb_l3_bank_ctrl.sv
// tb_l3_bank_ctrl - directed, table-driven bench for l3_bank_ctrl with a behavioural RAM32 array.
module tb_l3_bank_ctrl;

    localparam int NB    = 12;
    localparam int DEPTH = 3;
    localparam int IDW   = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_we = 1'b0;
    logic [8:0]      req_addr = '0;
    logic [31:0]     req_wdata = '0;
    logic [IDW-1:0]  req_id = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [31:0]     rsp_rdata;
    logic [IDW-1:0]  rsp_id;
    logic            rsp_err;
    logic [NB*5-1:0] ram_a;
    logic [NB*32-1:0] ram_d;
    logic [NB-1:0]   ram_we;
    logic [NB*32-1:0] ram_q;

    always #5 clk = ~clk;

    l3_bank_ctrl #(.NUM_BANKS(NB), .RSP_DEPTH(DEPTH), .ID_W(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_id(req_id),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_id(rsp_id), .rsp_err(rsp_err),
        .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q)
    );

    // RAM32 model: write at the edge with WE, Q shows the word addressed in the previous cycle.
    logic [31:0] mem [NB][32];
    logic [31:0] q [NB];

    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (ram_we[b]) mem[b][ram_a[b*5 +: 5]] <= ram_d[b*32 +: 32];
            q[b] <= mem[b][ram_a[b*5 +: 5]];
        end
    end

    always_comb begin
        ram_q = '0;
        for (int b = 0; b < NB; b++) ram_q[b*32 +: 32] = q[b];
    end

    typedef struct {
        logic        we;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  id;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_we_bank;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic [3:0]  id;
        logic        err;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    vec_t        vtab[$];
    exp_t        exp_q[$];
    logic [31:0] ref_mem [16][32];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int stalls = 0;
    int we_total = 0;
    int we_cnt [NB];
    logic [4:0]  last_a [NB];
    logic [31:0] last_d [NB];
    logic        ready_seen;
    logic        s_rsp_valid;
    logic [31:0] s_rsp_rdata;
    logic [3:0]  s_rsp_id;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One cycle: observe at the negedge, return just after the following posedge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        ready_seen  = req_ready;
        s_rsp_valid = rsp_valid;
        s_rsp_rdata = rsp_rdata;
        s_rsp_id    = rsp_id;
        if (rst_n) begin
            for (int b = 0; b < NB; b++) begin
                if (ram_we[b]) begin
                    we_cnt[b]++;
                    we_total++;
                    last_a[b] = ram_a[b*5 +: 5];
                    last_d[b] = ram_d[b*32 +: 32];
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_rsp: got id %0h, expected no response", rsp_id);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
                    checkOutput("rsp_rdata", rsp_rdata, e.rdata);
                    checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
                    if (e.chk_lat) checkOutput("rsp_latency", cyc - e.acc_cyc, 2);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] expRead(input logic [8:0] addr);
        logic [3:0] bk;
        bk = addr[8:5];
        if (int'(bk) >= NB) return 32'h0;
        return ref_mem[bk][addr[4:0]];
    endfunction

    // Present one request, hold it until accepted, and queue its expected response.
    task automatic applyStimulus(input logic we, input logic [8:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] id, input logic [31:0] exp_rdata,
                                 input logic exp_err, input bit chk_lat);
        exp_t e;
        int   waited;
        logic [3:0] bk;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_id    = id;
        waited    = 0;
        forever begin
            tick();
            if (ready_seen) break;
            stalls++;
            waited++;
            if (waited >= 100) break;
        end
        req_valid = 1'b0;
        if (!ready_seen) begin
            checkOutput("accept_timeout", 32'(ready_seen), 32'd1);
        end else begin
            e.rdata   = exp_rdata;
            e.id      = id;
            e.err     = exp_err;
            e.acc_cyc = cyc;
            e.chk_lat = chk_lat;
            exp_q.push_back(e);
            bk = addr[8:5];
            if (we && int'(bk) < NB) ref_mem[bk][addr[4:0]] = wdata;
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            checkOutput("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [8:0]  a;
        logic [31:0] d;

        for (int b = 0; b < NB; b++) begin
            q[b] = '0;
            we_cnt[b] = 0;
            last_a[b] = '0;
            last_d[b] = '0;
            for (int w = 0; w < 32; w++) mem[b][w] = '0;
        end
        for (int b = 0; b < 16; b++)
            for (int w = 0; w < 32; w++) ref_mem[b][w] = '0;

        // Directed vectors: {we, addr, wdata, id, expected rdata, expected err, bank expected to see WE}
        vtab.push_back('{1'b1, 9'h025, 32'hDEADBEEF, 4'h1, 32'h0,        1'b0, 1});
        vtab.push_back('{1'b0, 9'h025, 32'h0,        4'h2, 32'hDEADBEEF, 1'b0, -1});
        for (int b = 0; b < NB; b++) begin
            a = 9'(b * 32 + 31);
            d = 32'(b) * 32'h01010101;
            vtab.push_back('{1'b1, a, d, 4'(b + 3), 32'h0, 1'b0, b});
        end
        for (int b = 0; b < NB; b++) begin
            a = 9'(b * 32 + 31);
            d = 32'(b) * 32'h01010101;
            vtab.push_back('{1'b0, a, 32'h0, 4'(b + 5), d, 1'b0, -1});
        end
        vtab.push_back('{1'b0, 9'h1A0, 32'h0,        4'hA, 32'h0,        1'b1, -1});
        vtab.push_back('{1'b1, 9'h1E3, 32'h12345678, 4'hB, 32'h0,        1'b1, -1});
        vtab.push_back('{1'b0, 9'h0BF, 32'h0,        4'hC, 32'h05050505, 1'b0, -1});

        // Reset state
        #12;
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("reset_ram_we", 32'(ram_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("post_reset_req_ready", 32'(ready_seen), 32'd1);
        checkOutput("post_reset_rsp_valid", 32'(s_rsp_valid), 32'd0);

        // Table-driven single requests
        foreach (vtab[i]) begin
            for (int b = 0; b < NB; b++) we_cnt[b] = 0;
            we_total = 0;
            applyStimulus(vtab[i].we, vtab[i].addr, vtab[i].wdata, vtab[i].id,
                          vtab[i].exp_rdata, vtab[i].exp_err, 1'b1);
            waitDrain();
            if (vtab[i].exp_we_bank >= 0) begin
                checkOutput($sformatf("we_pulses[%0d]", i), we_cnt[vtab[i].exp_we_bank], 1);
                checkOutput($sformatf("we_addr[%0d]", i), 32'(last_a[vtab[i].exp_we_bank]),
                            32'(vtab[i].addr[4:0]));
                checkOutput($sformatf("we_data[%0d]", i), last_d[vtab[i].exp_we_bank], vtab[i].wdata);
            end
            checkOutput($sformatf("we_total[%0d]", i), we_total, (vtab[i].exp_we_bank >= 0) ? 1 : 0);
        end

        // Write then read the same word in consecutive cycles
        applyStimulus(1'b1, 9'h147, 32'hCAFEF00D, 4'h3, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 9'h147, 32'h0,        4'h4, 32'hCAFEF00D, 1'b0, 1'b1);
        waitDrain();

        // Back-pressure: only RSP_DEPTH requests fit while responses are held
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a = 9'(k * 32 + 31);
            applyStimulus(1'b0, a, 32'h0, 4'(k + 8), expRead(a), 1'b0, 1'b0);
        end
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 9'(3 * 32 + 31);
        req_id    = 4'hB;
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("bp_req_ready", 32'(ready_seen), 32'd0);
            checkOutput("bp_rsp_hold_id", 32'(s_rsp_id), 32'h8);
            checkOutput("bp_rsp_hold_data", s_rsp_rdata, 32'h0);
        end
        rsp_ready = 1'b1;
        for (int k = 3; k < 5; k++) begin
            a = 9'(k * 32 + 31);
            applyStimulus(1'b0, a, 32'h0, 4'(k + 8), expRead(a), 1'b0, 1'b0);
        end
        waitDrain();

        // Streaming reads, one per cycle
        stalls = 0;
        for (int i = 0; i < 32; i++) begin
            a = 9'((i % NB) * 32 + ((i % 3 == 0) ? 5 : 31));
            applyStimulus(1'b0, a, 32'h0, 4'(i), expRead(a), 1'b0, 1'b1);
        end
        checkOutput("stream_stalls", stalls, 0);
        waitDrain();

        // Reset with two responses buffered and one in flight
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a = 9'(k * 32 + 31);
            applyStimulus(1'b0, a, 32'h0, 4'(k), expRead(a), 1'b0, 1'b0);
        end
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("midreset_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("midreset_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("midreset_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("midreset_ram_a", 32'(|ram_a), 32'd0);
        exp_q.delete();
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("after_reset_req_ready", 32'(ready_seen), 32'd1);
            checkOutput("after_reset_rsp_valid", 32'(s_rsp_valid), 32'd0);
        end
        applyStimulus(1'b0, 9'h025, 32'h0, 4'h6, 32'hDEADBEEF, 1'b0, 1'b1);
        applyStimulus(1'b0, 9'(7 * 32 + 31), 32'h0, 4'h7, 32'h07070707, 1'b0, 1'b1);
        applyStimulus(1'b0, 9'h147, 32'h0, 4'h9, 32'hCAFEF00D, 1'b0, 1'b1);
        waitDrain();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/l3_bank_ctrl.md
Name: l3_bank_ctrl

Overview:
Request front-end that drives the RAM32 banks of the shared L3 cache block.
- Accepts single-word read/write requests on a valid/ready port.
- Decodes the bank and word, drives one bank's A/D/WE, and captures Q.
- Returns an ordered response (read data or write ack) on a second valid/ready port.
- Sits between the core-side interconnect and the array of NUM_BANKS RAM32 macros; it is the initiator side that the bank array responds to.

Parameters:
- NUM_BANKS, 12, number of RAM32 banks driven (1..16).
- RSP_DEPTH, 3, response buffer entries; minimum 2; 3 or more gives 1 request/cycle sustained.
- ID_W, 4, request tag width echoed on the response.

Ports:
- clk  in  1  single clock; also drives every RAM32 CLK.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid&&ready.
- req_we  in  1  1=write, 0=read.
- req_addr  in  9  [8:5] bank index, [4:0] word.
- req_wdata  in  32  write data.
- req_id  in  ID_W  tag.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when valid&&ready.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_id  out  ID_W  echoed tag.
- rsp_err  out  1  bank index >= NUM_BANKS.
- ram_a  out  NUM_BANKS*5  per-bank A, bank b at [5b+4:5b].
- ram_d  out  NUM_BANKS*32  per-bank D.
- ram_we  out  NUM_BANKS  per-bank WE.
- ram_q  in  NUM_BANKS*32  per-bank Q.

Behaviour:
- RAM32 timing:
  - Write occurs at the clk edge while WE=1.
  - Q holds the addressed word one cycle after A is presented.
- Issue cycle (T0), when req_valid&&req_ready and bank < NUM_BANKS:
  - Selected bank's ram_a = req_addr[4:0], ram_d = req_wdata, ram_we = req_we, all combinational in T0.
  - Every other bank: A=0, D=0, WE=0.
  - No accept → all banks A=0, D=0, WE=0.
- In-flight register (T0→T1) holds valid, we, bank, id, err.
- T1: push {rdata = we|err ? 0 : ram_q[bank], id, err} into the response FIFO.
  - Reads and writes both produce exactly one response.
  - Responses leave in acceptance order.
- Out-of-range bank:
  - No bank is accessed; all WE stay 0.
  - Response carries err=1, rdata=0.
- Flow control:
  - req_ready = (fifo_count + inflight_valid) < RSP_DEPTH, registered terms only.
  - No combinational path from rsp_ready or req_valid to req_ready.
- Response FIFO:
  - rsp_valid = fifo_count != 0; rsp_* show the head entry.
  - Push and pop in the same cycle are allowed, count unchanged.
  - Pop when empty cannot occur.
  - Push when full cannot occur (guaranteed by the credit rule).
- Latency: accept at T0 → rsp_valid no earlier than T2 (T1 push, registered FIFO output). Minimum 2 cycles.
- Throughput: 1 request/cycle sustained with RSP_DEPTH >= 3 and rsp_ready held at 1.
- Back-pressure: rsp_ready=0 holds rsp_* stable; req_ready drops once credits are exhausted.
- Back-to-back write then read of the same address in consecutive cycles: the read returns the new data (the RAM write completes at the T0 edge of the write).
- Reset (any time, including mid-operation):
  - In-flight entry and FIFO cleared; all pointers and counts 0.
  - rsp_valid=0, rsp_rdata=0, rsp_id=0, rsp_err=0.
  - All ram_we=0, ram_a=0, ram_d=0.
  - req_ready=1 from the first cycle after rst_n rises.
  - RAM contents are not cleared.
- The FIFO pointer wrap at RSP_DEPTH must be correct for non-power-of-2 depths.

Decomposition:
- Package l3_pkg holds:
  - L3_WORD_W=32, L3_RAM_AW=5, L3_BANK_W=4.
  - Bank/word field extraction functions.
  - Packed response struct {rdata, id, err}.
- Sub-module l3_rsp_fifo: parameterised depth/width synchronous FIFO with count output, async active-low reset.

Test Plan:
- Reset, then write 0xDEADBEEF to addr 0x025 (bank1, word5), then read 0x025 → write ack (err=0, rdata=0), then read rdata=0xDEADBEEF. Only ram_we[1] pulses, exactly one cycle.
- Walk all 12 banks writing data=bank*0x01010101 to word 31, then read back → 12 in-order responses with matching ids and data. Other banks' WE never asserted.
- Read addr 0x1A0 (bank 13, out of range) → rsp_err=1, rdata=0, id echoed. No ram_we asserted; next valid request still serviced.
- rsp_ready=0 with 5 back-to-back reads offered → exactly 3 accepted, req_ready=0. Then rsp_ready=1 → remaining 2 accepted, 5 responses in order, none lost or duplicated.
- Streaming 32 reads with rsp_ready=1 → one accept per cycle after the first, first response at T2.
- Assert rst_n=0 with 2 responses buffered and 1 in flight → rsp_valid=0 immediately. After release: no stale responses, req_ready=1, previously written data still readable.
